stream_decipher_rx: RTL and testbench

Receive-side counterpart of the `streamcipher` keystream block. It accepts a serial ciphertext bit stream MSB-first, one bit per `bit_valid` cycle, and XORs each bit with an internally generated 8-bit keystream. It reassembles the plaintext into bytes and hands each byte out over a valid/ready handshake. The block frames a fixed-length message of `MSG_BYTES` bytes and sits between the serial link and the byte-wide consumer.

---
 rtl/stream_decipher_rx.sv | 96 +++++++++
 tb/tb_stream_decipher_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_decipher_rx.sv
// stream_decipher_rx: serial ciphertext in, keystream-XORed plaintext bytes out.
// Define STREAM_RX_LFSR_EN for an LFSR keystream; otherwise the seed rotates.
module stream_decipher_rx #(
  parameter int MSG_BYTES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_load,
  input  logic [7:0] key_seed,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       byte_ready,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       msg_done,
  output logic       overrun,
  output logic       busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [7:0] LAST = 8'(MSG_BYTES - 1);

  logic [1:0] state;
  logic [7:0] kreg;
  logic [6:0] sreg;
  logic [2:0] bitcnt;
  logic [7:0] bytecnt;
  logic       fb;
  logic       p;
  logic       take;
  logic       last_bit;
  logic       last_byte;
  logic       drain;

  // keystream feedback selection
  always_comb begin
`ifdef STREAM_RX_LFSR_EN
    fb = kreg[7] ^ kreg[5] ^ kreg[4] ^ kreg[3];
`else
    fb = kreg[7];
`endif
  end

  assign p         = bit_in ^ kreg[7];
  assign take      = (state == S_ACTIVE) && bit_valid && !key_load;
  assign last_bit  = take && (bitcnt == 3'd7);
  assign last_byte = last_bit && (bytecnt == LAST);
  assign drain     = byte_valid && byte_ready;
  assign busy      = (state == S_ACTIVE);

  // framing, keystream and byte handshake state
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      kreg       <= 8'h00;
      sreg       <= 7'h00;
      bitcnt     <= 3'd0;
      bytecnt    <= 8'd0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      msg_done   <= 1'b0;
      overrun    <= 1'b0;
    end else if (key_load) begin
      state      <= S_ACTIVE;
      kreg       <= key_seed;
      sreg       <= 7'h00;
      bitcnt     <= 3'd0;
      bytecnt    <= 8'd0;
      byte_valid <= 1'b0;
      msg_done   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      msg_done <= last_byte;
      if (take) begin
        sreg   <= {sreg[5:0], p};
        kreg   <= {kreg[6:0], fb};
        bitcnt <= bitcnt + 3'd1;
      end
      if (last_bit) begin
        byte_out   <= {sreg, p};
        byte_valid <= 1'b1;
        bytecnt    <= bytecnt + 8'd1;
        if (byte_valid && !byte_ready)
          overrun <= 1'b1;
        if (last_byte)
          state <= S_DONE;
      end else if (drain) begin
        byte_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_decipher_rx.sv
// tb_stream_decipher_rx: random and directed stimulus against a message-level
// model that decrypts each byte as cipher XOR keystream-byte(seed, index).
module tb_stream_decipher_rx;

  localparam int MSG = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_load;
  logic [7:0] key_seed;
  logic       bit_valid;
  logic       bit_in;
  logic       byte_ready;
  logic       byte_valid;
  logic [7:0] byte_out;
  logic       msg_done;
  logic       overrun;
  logic       busy;

  stream_decipher_rx #(.MSG_BYTES(MSG)) dut (
    .clk(clk), .reset(reset),
    .key_load(key_load), .key_seed(key_seed),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .byte_ready(byte_ready), .byte_valid(byte_valid),
    .byte_out(byte_out), .msg_done(msg_done),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model: 0 idle, 1 active, 2 done
  int         m_st;
  logic [7:0] m_seed;
  int         m_nbits;
  logic [7:0] m_cacc;
  logic       m_bv, m_md, m_ov;
  logic [7:0] m_bo;

  logic       cap_en = 1'b0;
  logic [7:0] capq[$];
  int         done_cnt;

  function automatic logic [7:0] ks_byte(logic [7:0] s, int idx);
    logic [7:0] k;
`ifdef STREAM_RX_LFSR_EN
    k = s;
    for (int i = 0; i < 8 * idx; i++)
      k = {k[6:0], k[7] ^ k[5] ^ k[4] ^ k[3]};
`else
    k = s;
    if (idx < 0) k = 8'h00;
`endif
    return k;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic ate;
    ate = m_bv && byte_ready;
    if (reset) begin
      m_st = 0; m_seed = 0; m_nbits = 0; m_cacc = 0;
      m_bv = 0; m_md = 0; m_ov = 0; m_bo = 0;
    end else if (key_load) begin
      m_st = 1; m_seed = key_seed; m_nbits = 0; m_cacc = 0;
      m_bv = 0; m_md = 0; m_ov = 0;
    end else begin
      m_md = 0;
      if (m_st == 1 && bit_valid) begin
        m_cacc = {m_cacc[6:0], bit_in};
        m_nbits++;
        if (m_nbits % 8 == 0) begin
          m_bo = m_cacc ^ ks_byte(m_seed, m_nbits / 8 - 1);
          if (m_bv && !byte_ready) m_ov = 1;
          m_bv = 1;
          if (m_nbits / 8 == MSG) begin
            m_st = 2;
            m_md = 1;
          end
        end else if (ate) m_bv = 0;
      end else if (ate) m_bv = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("byte_valid", {7'b0, byte_valid}, {7'b0, m_bv});
    chk("byte_out", byte_out, m_bo);
    chk("msg_done", {7'b0, msg_done}, {7'b0, m_md});
    chk("overrun", {7'b0, overrun}, {7'b0, m_ov});
    chk("busy", {7'b0, busy}, {7'b0, m_st == 1});
    if (cap_en && byte_valid && byte_ready) capq.push_back(byte_out);
    if (cap_en && msg_done) done_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] c, input logic gaps);
    for (int i = 7; i >= 0; i--) begin
      bit_valid = 1'b1;
      bit_in    = c[i];
      tick();
      if (gaps) begin
        bit_valid = 1'b0;
        bit_in    = $urandom_range(0, 1);
        tick();
      end
    end
    bit_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] s);
    key_load = 1'b1;
    key_seed = s;
    tick();
    key_load = 1'b0;
  endtask

  logic [7:0] ct1[8];
  logic [7:0] pt1[8];

  initial begin
    ct1 = '{8'hB9, 8'hA3, 8'hBC, 8'hD0, 8'hA5, 8'hB6, 8'hBD, 8'hB7};
    pt1 = '{8'h49, 8'h53, 8'h4C, 8'h20, 8'h55, 8'h46, 8'h4D, 8'h47};
    reset = 1'b1; key_load = 0; key_seed = 0;
    bit_valid = 0; bit_in = 0; byte_ready = 0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_byte_out", byte_out, 8'h00);
    chk("reset_busy", {7'b0, busy}, 8'h00);

    // bits in IDLE are ignored
    send_byte(8'hFF, 1'b0);
    chk("idle_no_byte", {7'b0, byte_valid}, 8'h00);

    // rotate-mode reference message (LFSR mode checked by the model only)
    byte_ready = 1'b1;
    load(8'hF0);
    cap_en = 1'b1; done_cnt = 0;
    for (int b = 0; b < 8; b++) send_byte(ct1[b], 1'b0);
    tick(); tick();
    cap_en = 1'b0;
`ifndef STREAM_RX_LFSR_EN
    chk("msg1_count", 8'(capq.size()), 8'd8);
    for (int b = 0; b < 8; b++)
      if (b < capq.size()) chk("msg1_byte", capq[b], pt1[b]);
`endif
    chk("msg1_done_cnt", 8'(done_cnt), 8'd1);
    chk("msg1_overrun", {7'b0, overrun}, 8'h00);

    // bits in DONE are ignored
    send_byte(8'h5A, 1'b0);
    chk("done_no_byte", {7'b0, byte_valid}, 8'h00);

    // seed 01: first keystream byte is 01 in both modes
    load(8'h01);
    send_byte(8'h48, 1'b0);
    chk("seed01_byte", byte_out, 8'h49);

    // overrun across two unconsumed bytes
    byte_ready = 1'b0;
    load(8'h3C);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    chk("ovr_flag", {7'b0, overrun}, 8'h01);
    chk("ovr_second", byte_out, 8'h22 ^ ks_byte(8'h3C, 1));
    load(8'h3C);
    chk("ovr_cleared", {7'b0, overrun}, 8'h00);
    chk("ovr_bv_cleared", {7'b0, byte_valid}, 8'h00);

    // key_load colliding with a bit mid-byte
    byte_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; bit_in = i[0]; tick();
    end
    key_load = 1'b1; key_seed = 8'hA5; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    key_load = 1'b0;
    send_byte(8'hC3, 1'b0);
    chk("collide_byte", byte_out, 8'hC3 ^ 8'hA5);

    // gapped bits
    load(8'h77);
    send_byte(8'h10, 1'b1);
    send_byte(8'h9E, 1'b1);
    chk("gap_byte", byte_out, 8'h9E ^ ks_byte(8'h77, 1));

    // reset mid-message, then bits without key_load
    load(8'h42);
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1; tick();
    end
    bit_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_mid_busy", {7'b0, busy}, 8'h00);
    send_byte(8'hE7, 1'b0);
    chk("rst_mid_bv", {7'b0, byte_valid}, 8'h00);
    chk("rst_mid_out", byte_out, 8'h00);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      reset      = ($urandom_range(0, 999) == 0);
      key_load   = ($urandom_range(0, 149) == 0);
      key_seed   = 8'($urandom);
      bit_valid  = ($urandom_range(0, 3) != 0);
      bit_in     = $urandom_range(0, 1);
      byte_ready = $urandom_range(0, 1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
